// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width, reset PC,
// canonical NOP and the instruction bit positions that form the 9-bit decode
// address consumed by the control decoder.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Decode address = {instr[30], instr[14:12], instr[6:2]}
    localparam int CTRL_ADDR_W = 9;
    localparam int F7_BIT      = 30;
    localparam int F3_HI       = 14;
    localparam int F3_LO       = 12;
    localparam int OP_HI       = 6;
    localparam int OP_LO       = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with synchronous flush and an occupancy count. Used by
// fetch_stage both for the prefetch data buffer and for the PC tags of
// in-flight memory requests. The caller never pushes when full nor pops when
// empty; push and pop in the same cycle are allowed.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage write
    // NOTE: the storage array is deliberately not reset; the pointers and count
    // define which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the PC, issues word requests over a
// req/gnt/rvalid handshake, buffers returned words in a prefetch FIFO and
// presents the IF/ID register together with its 9-bit decode address.
// A redirect from EX flushes the stage; responses still in flight at that
// point are counted and discarded as they arrive.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to flag (sticky until rst)
// redirect targets whose low two bits are non-zero.
module fetch_stage #(
    parameter int                XLEN       = fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC   = fetch_stage_pkg::RESET_PC_DEFAULT,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    output logic                                   imem_req,
    output logic [XLEN-1:0]                        imem_addr,
    input  logic                                   imem_gnt,
    input  logic                                   imem_rvalid,
    input  logic [XLEN-1:0]                        imem_rdata,
    input  logic                                   redirect,
    input  logic [XLEN-1:0]                        redirect_pc,
    input  logic                                   stall,
    output logic                                   if_valid,
    output logic [XLEN-1:0]                        if_pc,
    output logic [XLEN-1:0]                        if_instr,
    output logic [fetch_stage_pkg::CTRL_ADDR_W-1:0] if_ctrl_addr,
    output logic                                   if_misalign
);

    import fetch_stage_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_cnt;

    logic [XLEN-1:0]  tag_head;
    logic             tag_empty;
    logic [CNT_W-1:0] tag_count_unused;

    entry_t           data_head;
    entry_t           rsp_entry;
    logic [CNT_W-1:0] data_count;
    logic             data_empty;

    logic             fire;
    logic             rsp_valid;
    logic             rsp_drop;
    logic             rsp_keep;
    logic             bypass;
    logic             data_push;
    logic             data_pop;
    logic [XLEN-1:0]  target_pc;

    // Credit rule: in-flight requests plus buffered words never exceed the
    // FIFO depth, so every response that is kept always has somewhere to go.
    assign imem_req  = !rst && !redirect &&
                       (({1'b0, outstanding} + {1'b0, data_count}) < (CNT_W + 1)'(FIFO_DEPTH));
    assign imem_addr = pc;
    assign fire      = imem_req && imem_gnt;

    // A response is only meaningful while a tag is waiting for it.
    assign rsp_valid = imem_rvalid && !tag_empty;
    assign rsp_drop  = rsp_valid && (drop_cnt != '0);
    assign rsp_keep  = rsp_valid && (drop_cnt == '0) && !redirect;

    // Straight into IF/ID when nothing older is queued and decode can accept.
    assign bypass    = rsp_keep && data_empty && !stall;
    assign data_push = rsp_keep && !bypass;
    assign data_pop  = !redirect && !stall && !data_empty;

    assign rsp_entry = '{pc: tag_head, instr: imem_rdata};
    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

    // Tags of requests granted but not yet answered, in request order
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (fire),
        .push_data (pc),
        .pop       (rsp_valid),
        .head      (tag_head),
        .count     (tag_count_unused),
        .empty     (tag_empty)
    );

    // Returned words waiting for decode to accept them
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (data_push),
        .push_data (rsp_entry),
        .pop       (data_pop),
        .head      (data_head),
        .count     (data_count),
        .empty     (data_empty)
    );

    // Next in-flight request count from this cycle's grant and response
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        outstanding_nxt = outstanding;
        if (fire) begin
            outstanding_nxt = outstanding_nxt + 1'b1;
        end
        if (rsp_valid) begin
            outstanding_nxt = outstanding_nxt - 1'b1;
        end
    end

    // PC, in-flight count and discard count
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                pc       <= target_pc;
                // Everything still in flight after this edge belongs to the
                // abandoned path, including entries already marked for drop.
                drop_cnt <= outstanding_nxt;
            end else begin
                if (fire) begin
                    pc <= pc + XLEN'(4);
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    // IF/ID register: oldest buffered word first, then bypass, else bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (!stall) begin
            if (!data_empty) begin
                if_valid <= 1'b1;
                if_pc    <= data_head.pc;
                if_instr <= data_head.instr;
            end else if (bypass) begin
                if_valid <= 1'b1;
                if_pc    <= tag_head;
                if_instr <= imem_rdata;
            end else begin
                if_valid <= 1'b0;
            end
        end
    end

    assign if_ctrl_addr = {if_instr[F7_BIT], if_instr[F3_HI:F3_LO], if_instr[OP_HI:OP_LO]};

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky flag for a redirect to a non word-aligned target
    always_ff @(posedge clk) begin
        if (rst) begin
            if_misalign <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            if_misalign <= 1'b1;
        end
    end
`else
    // Low target bits are simply dropped; nothing is reported.
    logic [1:0] unused_target_low;
    assign unused_target_low = redirect_pc[1:0];
    assign if_misalign       = 1'b0;
`endif

endmodule
